// File: rtl/alu_exec_unit.sv
// EX-stage execution unit: RV32I ALU ops registered in one cycle, RV32M mul/div/rem
// through an iterative radix-2 engine that holds in_ready low while it runs.
module alu_exec_unit #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      ALUOp,
    input  logic [6:0]      Funct7,
    input  logic [2:0]      Funct3,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal,
    output logic            out_valid
);

    localparam int unsigned SHW = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    typedef enum logic [4:0] {
        OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
        OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_ILL
    } op_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   hi_q, hi_d;      // product high half / partial remainder
    logic [XLEN-1:0]   lo_q, lo_d;      // multiplier / dividend shifting into quotient
    logic [XLEN-1:0]   opnd_q, opnd_d;  // multiplicand or divisor magnitude
    logic              neg_q, neg_d;    // negate product or quotient at the end
    logic              negr_q, negr_d;  // negate remainder at the end
    logic              hsel_q, hsel_d;  // mul: take high half; div: take remainder
    logic [XLEN-1:0]   result_q, result_d;
    logic              zero_q, zero_d;
    logic              illegal_q, illegal_d;
    logic              out_valid_q, out_valid_d;

    op_t               op_c;
    logic [SHW-1:0]    shamt_c;
    logic [XLEN-1:0]   alu_res_c;
    logic              is_mul_c, is_div_c, div_signed_c, div_zero_c, div_ovf_c;
    logic              a_neg_c, b_neg_c;
    logic [XLEN-1:0]   a_mag_c, b_mag_c;
    logic              accept_c, last_c;

    logic [XLEN:0]     mul_sum_c;
    logic [XLEN-1:0]   mul_hi_n_c, mul_lo_n_c;
    logic [2*XLEN-1:0] prod_c, prod_s_c;
    logic [XLEN-1:0]   mul_res_c;
    logic [XLEN:0]     div_shift_c, div_diff_c;
    logic              div_ge_c;
    logic [XLEN-1:0]   div_hi_n_c, div_lo_n_c, quot_s_c, rem_s_c, div_res_c;

    // Decode ALUOp/Funct7/Funct3 into one operation
    always_comb begin
        op_c = OP_ILL;
        case (ALUOp)
            2'b00: op_c = OP_ADD;
            2'b01: op_c = OP_SUB;
            2'b10: begin
                case (Funct7)
                    7'b0000000: begin
                        case (Funct3)
                            3'b000:  op_c = OP_ADD;
                            3'b001:  op_c = OP_SLL;
                            3'b010:  op_c = OP_SLT;
                            3'b011:  op_c = OP_SLTU;
                            3'b100:  op_c = OP_XOR;
                            3'b101:  op_c = OP_SRL;
                            3'b110:  op_c = OP_OR;
                            default: op_c = OP_AND;
                        endcase
                    end
                    7'b0100000: begin
                        if (Funct3 == 3'b000)      op_c = OP_SUB;
                        else if (Funct3 == 3'b101) op_c = OP_SRA;
                        else                       op_c = OP_ILL;
                    end
                    7'b0000001: begin
                        case (Funct3)
                            3'b000:  op_c = OP_MUL;
                            3'b001:  op_c = OP_MULH;
                            3'b010:  op_c = OP_MULHSU;
                            3'b011:  op_c = OP_MULHU;
                            3'b100:  op_c = OP_DIV;
                            3'b101:  op_c = OP_DIVU;
                            3'b110:  op_c = OP_REM;
                            default: op_c = OP_REMU;
                        endcase
                    end
                    default: op_c = OP_ILL;
                endcase
            end
            default: begin
                case (Funct3)
                    3'b000:  op_c = OP_ADD;
                    3'b001:  op_c = (Funct7 == 7'b0000000) ? OP_SLL : OP_ILL;
                    3'b010:  op_c = OP_SLT;
                    3'b011:  op_c = OP_SLTU;
                    3'b100:  op_c = OP_XOR;
                    3'b101: begin
                        if (Funct7 == 7'b0000000)      op_c = OP_SRL;
                        else if (Funct7 == 7'b0100000) op_c = OP_SRA;
                        else                           op_c = OP_ILL;
                    end
                    3'b110:  op_c = OP_OR;
                    default: op_c = OP_AND;
                endcase
            end
        endcase
    end

    // Operand classification, magnitudes and divide special cases
    always_comb begin
        is_mul_c     = (op_c == OP_MUL) || (op_c == OP_MULH) || (op_c == OP_MULHSU) || (op_c == OP_MULHU);
        is_div_c     = (op_c == OP_DIV) || (op_c == OP_DIVU) || (op_c == OP_REM) || (op_c == OP_REMU);
        div_signed_c = (op_c == OP_DIV) || (op_c == OP_REM);
        a_neg_c      = A[XLEN-1] & ((op_c == OP_MUL) || (op_c == OP_MULH) || (op_c == OP_MULHSU) || div_signed_c);
        b_neg_c      = B[XLEN-1] & ((op_c == OP_MUL) || (op_c == OP_MULH) || div_signed_c);
        a_mag_c      = a_neg_c ? ((~A) + XLEN'(1)) : A;
        b_mag_c      = b_neg_c ? ((~B) + XLEN'(1)) : B;
        div_zero_c   = (B == '0);
        div_ovf_c    = div_signed_c && (A == {1'b1, {(XLEN-1){1'b0}}}) && (B == '1);
        shamt_c      = B[SHW-1:0];
    end

    // Single-cycle results, including illegal and divide special cases
    always_comb begin
        alu_res_c = '0;
        case (op_c)
            OP_ADD:  alu_res_c = A + B;
            OP_SUB:  alu_res_c = A - B;
            OP_SLL:  alu_res_c = A << shamt_c;
            OP_SLT:  alu_res_c = XLEN'($signed(A) < $signed(B));
            OP_SLTU: alu_res_c = XLEN'(A < B);
            OP_XOR:  alu_res_c = A ^ B;
            OP_SRL:  alu_res_c = A >> shamt_c;
            OP_SRA:  alu_res_c = XLEN'($signed(A) >>> shamt_c);
            OP_OR:   alu_res_c = A | B;
            OP_AND:  alu_res_c = A & B;
            OP_DIV, OP_DIVU: alu_res_c = div_zero_c ? '1 : A;
            OP_REM, OP_REMU: alu_res_c = div_zero_c ? A : '0;
            default: alu_res_c = '0;
        endcase
    end

    // One engine step for each algorithm plus the sign-fixed final values
    always_comb begin
        mul_sum_c   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        mul_hi_n_c  = mul_sum_c[XLEN:1];
        mul_lo_n_c  = {mul_sum_c[0], lo_q[XLEN-1:1]};
        prod_c      = {mul_hi_n_c, mul_lo_n_c};
        prod_s_c    = neg_q ? ((~prod_c) + (2*XLEN)'(1)) : prod_c;
        mul_res_c   = hsel_q ? prod_s_c[2*XLEN-1:XLEN] : prod_s_c[XLEN-1:0];

        div_shift_c = {hi_q, lo_q[XLEN-1]};
        div_diff_c  = div_shift_c - {1'b0, opnd_q};
        div_ge_c    = ~div_diff_c[XLEN];
        div_hi_n_c  = div_ge_c ? div_diff_c[XLEN-1:0] : div_shift_c[XLEN-1:0];
        div_lo_n_c  = {lo_q[XLEN-2:0], div_ge_c};
        quot_s_c    = neg_q ? ((~div_lo_n_c) + XLEN'(1)) : div_lo_n_c;
        rem_s_c     = negr_q ? ((~div_hi_n_c) + XLEN'(1)) : div_hi_n_c;
        div_res_c   = hsel_q ? rem_s_c : quot_s_c;

        last_c      = (cnt_q == CNT_W'(XLEN - 1));
    end

    assign in_ready = (state_q == S_IDLE) & ~reset;
    assign accept_c = in_valid & in_ready & ~flush;

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        opnd_d      = opnd_q;
        neg_d       = neg_q;
        negr_d      = negr_q;
        hsel_d      = hsel_q;
        result_d    = result_q;
        zero_d      = zero_q;
        illegal_d   = illegal_q;
        out_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    if (is_mul_c) begin
                        state_d = S_MUL;
                        cnt_d   = '0;
                        hi_d    = '0;
                        lo_d    = b_mag_c;
                        opnd_d  = a_mag_c;
                        neg_d   = a_neg_c ^ b_neg_c;
                        negr_d  = 1'b0;
                        hsel_d  = (op_c != OP_MUL);
                    end else if (is_div_c && !div_zero_c && !div_ovf_c) begin
                        state_d = S_DIV;
                        cnt_d   = '0;
                        hi_d    = '0;
                        lo_d    = a_mag_c;
                        opnd_d  = b_mag_c;
                        neg_d   = a_neg_c ^ b_neg_c;
                        negr_d  = a_neg_c;
                        hsel_d  = (op_c == OP_REM) || (op_c == OP_REMU);
                    end else begin
                        out_valid_d = 1'b1;
                        result_d    = alu_res_c;
                        zero_d      = (alu_res_c == '0);
                        illegal_d   = (op_c == OP_ILL);
                    end
                end
            end
            S_MUL: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    hi_d  = mul_hi_n_c;
                    lo_d  = mul_lo_n_c;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_c) begin
                        state_d     = S_IDLE;
                        out_valid_d = 1'b1;
                        result_d    = mul_res_c;
                        zero_d      = (mul_res_c == '0);
                        illegal_d   = 1'b0;
                    end
                end
            end
            S_DIV: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    hi_d  = div_hi_n_c;
                    lo_d  = div_lo_n_c;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_c) begin
                        state_d     = S_IDLE;
                        out_valid_d = 1'b1;
                        result_d    = div_res_c;
                        zero_d      = (div_res_c == '0);
                        illegal_d   = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            opnd_q      <= '0;
            neg_q       <= 1'b0;
            negr_q      <= 1'b0;
            hsel_q      <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            opnd_q      <= opnd_d;
            neg_q       <= neg_d;
            negr_q      <= negr_d;
            hsel_q      <= hsel_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            illegal_q   <= illegal_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign result    = result_q;
    assign zero      = zero_q;
    assign illegal   = illegal_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed spec vectors plus random traffic against a reference model.
module tb_alu_exec_unit;

    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            reset, flush, in_valid, in_ready;
    logic [1:0]      aluop;
    logic [6:0]      f7;
    logic [2:0]      f3;
    logic [XLEN-1:0] a, b, result;
    logic            zero, illegal, out_valid;

    alu_exec_unit #(.XLEN(XLEN), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .ALUOp(aluop), .Funct7(f7), .Funct3(f3), .A(a), .B(b),
        .result(result), .zero(zero), .illegal(illegal), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference: name the operation, then evaluate it with 64-bit arithmetic
    function automatic void ref_op(input logic [1:0] op, input logic [6:0] f7v, input logic [2:0] f3v,
                                   input logic [31:0] av, input logic [31:0] bv,
                                   output logic [31:0] r, output bit ill, output bit long_op);
        string base_ops [8] = '{"add", "sll", "slt", "sltu", "xor", "srl", "or", "and"};
        string md_ops   [8] = '{"mul", "mulh", "mulhsu", "mulhu", "div", "divu", "rem", "remu"};
        string kind;
        logic signed [63:0] sa, sb, ua, ub, p;
        bit ovf;
        sa = {{32{av[31]}}, av};
        sb = {{32{bv[31]}}, bv};
        ua = {32'b0, av};
        ub = {32'b0, bv};
        ovf = (av == 32'h8000_0000) && (bv == 32'hFFFF_FFFF);
        kind = "ill";
        if (op == 2'b00) kind = "add";
        else if (op == 2'b01) kind = "sub";
        else if (op == 2'b10) begin
            if (f7v == 7'h00) kind = base_ops[f3v];
            else if (f7v == 7'h20 && f3v == 3'd0) kind = "sub";
            else if (f7v == 7'h20 && f3v == 3'd5) kind = "sra";
            else if (f7v == 7'h01) kind = md_ops[f3v];
        end else begin
            kind = base_ops[f3v];
            if (f3v == 3'd1 && f7v != 7'h00) kind = "ill";
            if (f3v == 3'd5) kind = (f7v == 7'h00) ? "srl" : (f7v == 7'h20) ? "sra" : "ill";
        end
        r = 32'h0; ill = 1'b0; long_op = 1'b0;
        if (kind == "add") r = av + bv;
        else if (kind == "sub") r = av - bv;
        else if (kind == "sll") r = av << bv[4:0];
        else if (kind == "slt") r = (sa < sb) ? 32'd1 : 32'd0;
        else if (kind == "sltu") r = (av < bv) ? 32'd1 : 32'd0;
        else if (kind == "xor") r = av ^ bv;
        else if (kind == "srl") r = av >> bv[4:0];
        else if (kind == "sra") r = 32'($signed(av) >>> bv[4:0]);
        else if (kind == "or") r = av | bv;
        else if (kind == "and") r = av & bv;
        else if (kind == "mul") begin p = sa * sb; r = p[31:0]; long_op = 1'b1; end
        else if (kind == "mulh") begin p = sa * sb; r = p[63:32]; long_op = 1'b1; end
        else if (kind == "mulhsu") begin p = sa * ub; r = p[63:32]; long_op = 1'b1; end
        else if (kind == "mulhu") begin p = ua * ub; r = p[63:32]; long_op = 1'b1; end
        else if (kind == "div") begin
            if (bv == 0) r = 32'hFFFF_FFFF;
            else begin p = sa / sb; r = p[31:0]; long_op = !ovf; end
        end else if (kind == "divu") begin
            if (bv == 0) r = 32'hFFFF_FFFF;
            else begin p = ua / ub; r = p[31:0]; long_op = 1'b1; end
        end else if (kind == "rem") begin
            if (bv == 0) r = av;
            else begin p = sa % sb; r = p[31:0]; long_op = !ovf; end
        end else if (kind == "remu") begin
            if (bv == 0) r = av;
            else begin p = ua % ub; r = p[31:0]; long_op = 1'b1; end
        end else ill = 1'b1;
    endfunction

    // Model state: cycles left until a long op completes, and the outputs expected now
    int          busy_left = 0;
    logic [31:0] p_res = 0;
    logic [31:0] e_res = 0;
    bit          e_ov = 0, e_zero = 0, e_ill = 0, started = 0;

    always @(posedge clk) begin
        logic [31:0] r;
        bit il, lg;
        if (reset) begin
            busy_left = 0; e_ov = 0; e_res = 0; e_zero = 0; e_ill = 0;
        end else begin
            e_ov = 0;
            if (busy_left > 0) begin
                if (flush) busy_left = 0;
                else begin
                    busy_left--;
                    if (busy_left == 0) begin
                        e_ov = 1; e_res = p_res; e_ill = 0; e_zero = (p_res == 0);
                    end
                end
            end else if (in_valid && !flush) begin
                ref_op(aluop, f7, f3, a, b, r, il, lg);
                if (lg) begin
                    busy_left = XLEN; p_res = r;
                end else begin
                    e_ov = 1; e_res = r; e_ill = il; e_zero = (r == 0);
                end
            end
        end
        started = 1;
    end

    // Compare every output against the model each cycle
    always @(posedge clk) begin
        #2;
        if (started) begin
            chk("out_valid", 32'(out_valid), 32'(e_ov));
            chk("in_ready", 32'(in_ready), 32'(!reset && busy_left == 0));
            chk("result", result, e_res);
            chk("zero", 32'(zero), 32'(e_zero));
            chk("illegal", 32'(illegal), 32'(e_ill));
        end
    end

    // Issue one op from idle and check the literal result and latency
    task automatic do_op(input logic [1:0] op, input logic [6:0] f7v, input logic [2:0] f3v,
                         input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] exp_r, input bit exp_ill, input int exp_lat, input string nm);
        int lat;
        bit got;
        @(negedge clk);
        aluop = op; f7 = f7v; f3 = f3v; a = av; b = bv; in_valid = 1'b1;
        lat = 0; got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk);
            #2;
            in_valid = 1'b0;
            lat++;
            if (out_valid) got = 1'b1;
        end
        chk({nm, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({nm, "_res"}, result, exp_r);
        chk({nm, "_ill"}, 32'(illegal), 32'(exp_ill));
        chk({nm, "_zero"}, 32'(zero), 32'(exp_r == 0));
    endtask

    // Start a DIVU, then abort it in its 10th busy cycle with flush or reset
    task automatic abort_divu(input bit use_reset);
        int ov_cnt;
        @(negedge clk);
        aluop = 2'b10; f7 = 7'h01; f3 = 3'd5; a = 32'd1000; b = 32'd7; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        if (use_reset) reset = 1'b1; else flush = 1'b1;
        @(negedge clk);
        if (use_reset) begin
            chk("rst_abort_res", result, 32'h0);
            chk("rst_abort_zero", 32'(zero), 32'h0);
            chk("rst_abort_ill", 32'(illegal), 32'h0);
            chk("rst_abort_ov", 32'(out_valid), 32'h0);
            reset = 1'b0;
        end else begin
            flush = 1'b0;
            chk("flush_abort_ready", 32'(in_ready), 32'h1);
            chk("flush_abort_ov", 32'(out_valid), 32'h0);
            do_op(2'b10, 7'h00, 3'd0, 32'd20, 32'd22, 32'd42, 1'b0, 1, "add_after_flush");
        end
        ov_cnt = 0;
        repeat (40) begin
            @(posedge clk); #2;
            if (out_valid) ov_cnt++;
        end
        chk(use_reset ? "rst_no_ov" : "flush_no_ov", 32'(ov_cnt), 32'h0);
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
        aluop = 2'b00; f7 = 7'h00; f3 = 3'd0; a = 32'h0; b = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(in_ready), 32'h0);
        chk("rst_result", result, 32'h0);
        chk("rst_ov", 32'(out_valid), 32'h0);
        reset = 1'b0;
        #1;
        chk("post_rst_ready", 32'(in_ready), 32'h1);

        do_op(2'b10, 7'h00, 3'd0, 32'd5, 32'd7, 32'd12, 1'b0, 1, "add");
        do_op(2'b01, 7'h00, 3'd0, 32'h1234, 32'h1234, 32'h0, 1'b0, 1, "sub_zero");
        do_op(2'b11, 7'h20, 3'd5, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1, "srai");
        do_op(2'b11, 7'h00, 3'd2, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1, "slti");
        do_op(2'b11, 7'h01, 3'd1, 32'd3, 32'd1, 32'h0, 1'b1, 1, "slli_bad");
        do_op(2'b10, 7'h01, 3'd1, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFF, 1'b0, 33, "mulh");
        do_op(2'b10, 7'h01, 3'd0, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, 1'b0, 33, "mul");
        do_op(2'b10, 7'h01, 3'd2, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFF, 1'b0, 33, "mulhsu");
        do_op(2'b10, 7'h01, 3'd3, 32'hFFFF_FFFF, 32'd3, 32'h0000_0002, 1'b0, 33, "mulhu");
        do_op(2'b10, 7'h01, 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 33, "div");
        do_op(2'b10, 7'h01, 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0, 33, "rem");
        do_op(2'b10, 7'h01, 3'd4, 32'd7, 32'd0, 32'hFFFF_FFFF, 1'b0, 1, "div_by0");
        do_op(2'b10, 7'h01, 3'd7, 32'd7, 32'd0, 32'd7, 1'b0, 1, "remu_by0");
        do_op(2'b10, 7'h01, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1, "div_ovf");
        do_op(2'b10, 7'h01, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0, 1, "rem_ovf");
        do_op(2'b10, 7'h03, 3'd0, 32'd1, 32'd2, 32'h0, 1'b1, 1, "illegal");

        // in_valid with flush in idle must not be accepted
        @(negedge clk);
        aluop = 2'b00; a = 32'd1; b = 32'd1; in_valid = 1'b1; flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_blocks_accept", 32'(out_valid), 32'h0);

        abort_divu(1'b0);
        do_op(2'b00, 7'h7F, 3'd7, 32'd9, 32'd1, 32'd10, 1'b0, 1, "add_fill");
        abort_divu(1'b1);

        // Random traffic with occasional flush and reset
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            aluop = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0: f7 = 7'h00;
                1: f7 = 7'h20;
                2: f7 = 7'h01;
                default: f7 = 7'($urandom);
            endcase
            f3       = 3'($urandom);
            a        = rnd_operand();
            b        = rnd_operand();
            in_valid = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 19) == 0);
            reset    = ($urandom_range(0, 299) == 0);
        end
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0; reset = 1'b0;
        repeat (40) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
